// File: rtl/cmd_issuer.sv
// Host-side command source: queues line-draw requests, packs them into 48-bit commands and
// drives the decoder handshake one command at a time, with a cmd_done timeout on draws.
module cmd_issuer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_opcode,
    input  logic [8:0]                    req_x1,
    input  logic [8:0]                    req_y1,
    input  logic [8:0]                    req_x2,
    input  logic [8:0]                    req_y2,
    input  logic [7:0]                    req_color,
    output logic [47:0]                   cmd_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    input  logic                          cmd_done,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StHold, StRelease} state_e;

    state_e          state_q, state_d;
    logic [47:0]     cmd_data_q, cmd_data_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [47:0]     mem_q [FIFO_DEPTH];

    logic            push, pop, is_draw;
    logic [47:0]     req_word;

    assign req_word  = {req_opcode, req_x1, req_y1, req_x2, req_y2, 2'b00, req_color};
    // No bypass: a full queue refuses even when the head is popped in the same cycle.
    assign req_ready = (count_q != CW'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign is_draw   = (cmd_data_q[47:46] == 2'b00);

    always_comb begin
        state_d    = state_q;
        cmd_data_d = cmd_data_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StIdle, StRelease: begin
                state_d = StIdle;
                if (count_q != '0) begin
                    state_d    = StIssue;
                    cmd_data_d = mem_q[rd_ptr_q];
                    pop        = 1'b1;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            StHold: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (is_draw) begin
                    if (cmd_done) begin
                        state_d = StRelease;
                    end else if (hold_cnt_q == HW'(TIMEOUT - 1)) begin
                        state_d   = StRelease;
                        timeout_d = 1'b1;
                    end
                end else if (hold_cnt_q == HW'(1)) begin
                    // Non-draw commands need a fixed parse + dispatch window only.
                    state_d = StRelease;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cmd_data_q <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_data_q <= cmd_data_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_word;
    end

    assign cmd_valid   = (state_q == StIssue) || (state_q == StHold);
    assign cmd_data    = cmd_data_q;
    assign timeout_err = timeout_q;
    assign busy        = (state_q != StIdle) || (count_q != '0);
    assign fifo_count  = count_q;

endmodule
